// File: rtl/mem_access_unit_if.sv
// Data-memory port between the MEM-stage access unit (master) and the data memory (slave).
interface mem_access_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] dmem_addr;
    logic            dmem_read;
    logic            dmem_write;
    logic [3:0]      dmem_wmask;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_resp;

    modport master (
        output dmem_addr, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_addr, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I MEM-stage load/store unit: issues one data-memory request per access, holds it
// until the response, stalls the pipeline meanwhile, and formats store/load data.
module mem_access_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic              advance_i,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   store_data_i,
    mem_access_unit_if.master dmem,
    output logic [XLEN-1:0]   load_data_o,
    output logic              mem_stall,
    output logic              misaligned_o,
    output logic [CNT_W-1:0]  stall_cycles_o
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              flushed_q, flushed_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              access, misal, start, is_wr;
    logic [3:0]        st_mask;
    logic [XLEN-1:0]   st_wdata;
    logic [XLEN-1:0]   req_addr, req_wdata;
    logic [3:0]        req_mask;
    logic              req_rd, req_wr, stall;

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return rdata;
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return '0;
        endcase
    endfunction

    always_comb begin
        access = valid_i && (is_load_i || is_store_i) && !flush_i;
        is_wr  = is_store_i && !is_load_i;
        case (funct3_i)
            3'b001, 3'b101: misal = addr_i[0];
            3'b010:         misal = |addr_i[1:0];
            default:        misal = 1'b0;
        endcase
        st_mask  = 4'b0000;
        st_wdata = '0;
        if (is_wr) begin
            case (funct3_i)
                3'b000: begin
                    st_mask  = 4'b0001 << addr_i[1:0];
                    st_wdata = {4{store_data_i[7:0]}};
                end
                3'b001: begin
                    st_mask  = 4'b0011 << addr_i[1:0];
                    st_wdata = {2{store_data_i[15:0]}};
                end
                3'b010: begin
                    st_mask  = 4'b1111;
                    st_wdata = store_data_i;
                end
                default: begin
                    st_mask  = 4'b0000;
                    st_wdata = '0;
                end
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wmask_d     = wmask_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        flushed_d   = flushed_q;
        load_data_d = load_data_q;
        req_addr    = '0;
        req_rd      = 1'b0;
        req_wr      = 1'b0;
        req_mask    = 4'b0000;
        req_wdata   = '0;
        stall       = 1'b0;
        start       = (state_q == IDLE) && access && !misal;
        misaligned_o = (state_q == IDLE) && access && misal;

        case (state_q)
            IDLE: begin
                if (start) begin
                    req_addr  = {addr_i[XLEN-1:2], 2'b00};
                    req_rd    = !is_wr;
                    req_wr    = is_wr;
                    req_mask  = st_mask;
                    req_wdata = st_wdata;
                    stall     = 1'b1;
                    addr_d    = addr_i;
                    wmask_d   = st_mask;
                    wdata_d   = st_wdata;
                    funct3_d  = funct3_i;
                    rd_d      = !is_wr;
                    wr_d      = is_wr;
                    flushed_d = 1'b0;
                    if (dmem.dmem_resp) begin
                        state_d     = DONE;
                        load_data_d = is_wr ? '0 : load_ext(funct3_i, addr_i[1:0], dmem.dmem_rdata);
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                req_addr  = {addr_q[XLEN-1:2], 2'b00};
                req_rd    = rd_q;
                req_wr    = wr_q;
                req_mask  = wmask_q;
                req_wdata = wdata_q;
                stall     = 1'b1;
                flushed_d = flushed_q || flush_i;
                // A squashed access still completes on the bus but never reaches DONE.
                if (dmem.dmem_resp) begin
                    if (flushed_q || flush_i) begin
                        state_d     = IDLE;
                        load_data_d = '0;
                    end else begin
                        state_d     = DONE;
                        load_data_d = rd_q ? load_ext(funct3_q, addr_q[1:0], dmem.dmem_rdata) : '0;
                    end
                end
            end
            DONE: begin
                if (advance_i || flush_i) begin
                    state_d     = IDLE;
                    load_data_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wmask_q     <= 4'b0000;
            wdata_q     <= '0;
            funct3_q    <= 3'b000;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            flushed_q   <= 1'b0;
            load_data_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wmask_q     <= wmask_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            flushed_q   <= flushed_d;
            load_data_q <= load_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign dmem.dmem_addr  = req_addr;
    assign dmem.dmem_read  = req_rd;
    assign dmem.dmem_write = req_wr;
    assign dmem.dmem_wmask = req_mask;
    assign dmem.dmem_wdata = req_wdata;
    assign load_data_o     = load_data_q;
    assign mem_stall       = stall;
    assign stall_cycles_o  = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected load results are queued at issue and
// compared in the result cycle; request, stall, misalignment and reset behaviour checked inline.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        valid_i, flush_i, advance_i, is_load_i, is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, store_data_i;
    logic [31:0] load_data_o;
    logic        mem_stall, misaligned_o;
    logic [31:0] stall_cycles_o;

    mem_access_unit_if #(.XLEN(32)) dmem ();

    mem_access_unit #(.XLEN(32), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid_i),
        .flush_i        (flush_i),
        .advance_i      (advance_i),
        .is_load_i      (is_load_i),
        .is_store_i     (is_store_i),
        .funct3_i       (funct3_i),
        .addr_i         (addr_i),
        .store_data_i   (store_data_i),
        .dmem           (dmem.master),
        .load_data_o    (load_data_o),
        .mem_stall      (mem_stall),
        .misaligned_o   (misaligned_o),
        .stall_cycles_o (stall_cycles_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_stall_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        valid_i = 0; is_load_i = 0; is_store_i = 0; flush_i = 0;
        funct3_i = 3'($urandom); addr_i = $urandom; store_data_i = $urandom;
        dmem.dmem_resp = 0; dmem.dmem_rdata = $urandom;
    endtask

    // One complete access: n = cycles until dmem_resp (0 = same cycle), flush_at = WAIT
    // cycle index carrying flush_i (<=0 none), hold = DONE cycles without advance_i.
    task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                              input int n, input int flush_at, input int hold,
                              input logic [31:0] e_addr, input logic [3:0] e_mask,
                              input logic [31:0] e_wdata, input logic [31:0] e_load);
        bit          flushed = 0;
        int          reqs = 0;
        logic [31:0] exp_ld;
        exp_stall_cnt += 32'(n + 1);
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            if (c == 0) begin
                valid_i = 1; is_load_i = ld; is_store_i = st; funct3_i = f3;
                addr_i = a; store_data_i = sd; flush_i = 0; advance_i = 0;
            end else begin
                idle_inputs();
                advance_i = 1'($urandom);
                flush_i = (c == flush_at);
                if (flush_i) flushed = 1;
            end
            dmem.dmem_resp  = (c == n);
            dmem.dmem_rdata = (c == n) ? rd : $urandom;
            #1;
            if (c == 0) chk("ld_data_idle", load_data_o, 32'h0);
            if (c == 0 || c == n) begin
                chk("req_addr", dmem.dmem_addr, e_addr);
                chk("req_mask", 32'(dmem.dmem_wmask), 32'(e_mask));
                chk("req_wdata", dmem.dmem_wdata, e_wdata);
                chk("req_write", 32'(dmem.dmem_write), 32'(st));
            end
            chk("stall_wait", 32'(mem_stall), 32'h1);
            if (dmem.dmem_read || dmem.dmem_write) reqs++;
        end
        chk("req_cycles", reqs, n + 1);
        if (!flushed) begin
            sb_q.push_back(e_load);
            @(negedge clk);
            idle_inputs();
            advance_i = (hold == 0);
            #1;
            exp_ld = sb_q.pop_front();
            chk("ld_data", load_data_o, exp_ld);
            chk("stall_done", 32'(mem_stall), 32'h0);
            chk("req_dropped", 32'(dmem.dmem_read | dmem.dmem_write), 32'h0);
            chk("stall_cnt", stall_cycles_o, exp_stall_cnt);
            for (int h = 1; h <= hold; h++) begin
                @(negedge clk);
                valid_i = 1; is_load_i = 1; funct3_i = 3'b010; addr_i = 32'h600;
                advance_i = (h == hold);
                #1;
                chk("ld_hold", load_data_o, exp_ld);
                chk("no_issue_in_done", 32'(mem_stall), 32'h0);
            end
        end
    endtask

    task automatic misaligned_case(input logic st, input logic [2:0] f3, input logic [31:0] a);
        @(negedge clk);
        idle_inputs();
        valid_i = 1; is_load_i = !st; is_store_i = st; funct3_i = f3; addr_i = a;
        dmem.dmem_resp = 1;
        #1;
        chk("misal_flag", 32'(misaligned_o), 32'h1);
        chk("misal_noreq", 32'(dmem.dmem_read | dmem.dmem_write), 32'h0);
        chk("misal_nostall", 32'(mem_stall), 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("misal_clear", 32'(misaligned_o), 32'h0);
    endtask

    initial begin
        rst = 1;
        advance_i = 0;
        idle_inputs();
        #3;
        chk("rst_read", 32'(dmem.dmem_read), 32'h0);
        chk("rst_stall", 32'(mem_stall), 32'h0);
        chk("rst_ld_data", load_data_o, 32'h0);
        chk("rst_cnt", stall_cycles_o, 32'h0);
        @(negedge clk);
        rst = 0;

        run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0, 1,
                   32'h100, 4'b0000, 32'h0, 32'hDEADBEEF);
        run_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1, 0, 0,
                   32'h100, 4'b0000, 32'h0, 32'hFFFFFF80);
        run_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 0,
                   32'h100, 4'b0000, 32'h0, 32'h00000080);
        run_access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 2, 0, 2,
                   32'h100, 4'b0000, 32'h0, 32'hFFFF80FF);
        run_access(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 0, 0, 0,
                   32'h100, 4'b0000, 32'h0, 32'h000080FF);
        run_access(1, 0, 3'b000, 32'h001, 32'h0, 32'h00007F00, 0, 0, 0,
                   32'h000, 4'b0000, 32'h0, 32'h0000007F);
        run_access(0, 1, 3'b000, 32'h201, 32'h000000AB, 32'h12345678, 0, 0, 0,
                   32'h200, 4'b0010, 32'hABABABAB, 32'h0);
        run_access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h12345678, 1, 0, 0,
                   32'h200, 4'b1100, 32'hABCDABCD, 32'h0);
        run_access(0, 1, 3'b010, 32'h300, 32'h11223344, 32'h12345678, 2, 0, 0,
                   32'h300, 4'b1111, 32'h11223344, 32'h0);
        run_access(1, 0, 3'b110, 32'h104, 32'h0, 32'hCAFEF00D, 1, 0, 0,
                   32'h104, 4'b0000, 32'h0, 32'h0);

        misaligned_case(1, 3'b001, 32'h203);
        misaligned_case(0, 3'b010, 32'h101);
        misaligned_case(0, 3'b101, 32'h101);
        misaligned_case(1, 3'b010, 32'h202);

        // Flushed LW: the following access must start at once (no DONE cycle in between).
        run_access(1, 0, 3'b010, 32'h400, 32'h0, 32'h55AA55AA, 2, 1, 0,
                   32'h400, 4'b0000, 32'h0, 32'h0);
        run_access(1, 0, 3'b000, 32'h401, 32'h0, 32'h0000C300, 1, 0, 0,
                   32'h400, 4'b0000, 32'h0, 32'hFFFFFFC3);

        // Reset asserted between clock edges while waiting.
        @(negedge clk);
        idle_inputs();
        valid_i = 1; is_load_i = 1; funct3_i = 3'b010; addr_i = 32'h500;
        #1;
        chk("pre_rst_stall", 32'(mem_stall), 32'h1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("wait_read", 32'(dmem.dmem_read), 32'h1);
        #1;
        rst = 1;
        #1;
        chk("async_rst_read", 32'(dmem.dmem_read), 32'h0);
        chk("async_rst_stall", 32'(mem_stall), 32'h0);
        chk("async_rst_cnt", stall_cycles_o, 32'h0);
        exp_stall_cnt = 0;
        @(negedge clk);
        rst = 0;
        run_access(1, 0, 3'b010, 32'h504, 32'h0, 32'h0BADF00D, 1, 0, 0,
                   32'h504, 4'b0000, 32'h0, 32'h0BADF00D);

        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit of the RV32I pipeline.
- Sits between the EX/MEM pipeline register and the data memory port, and produces the load result written into the MEM/WB register.
- Issues one read or write per load/store and holds the request until `dmem_resp`. Aligns store bytes and sign/zero-extends load data.
- Raises `mem_stall` so the pipeline-wide `load` enable is dropped while an access is outstanding.

Parameters:
- XLEN, 32, data/address width (only 32 supported)
- CNT_W, 32, width of saturating stall-cycle counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- valid_i  in  1  EX/MEM instruction valid
- flush_i  in  1  squash current MEM instruction
- advance_i  in  1  pipeline load enable (MEM/WB accepts this cycle)
- is_load_i  in  1  instruction is a load
- is_store_i  in  1  instruction is a store
- funct3_i  in  3  RV32I load/store funct3
- addr_i  in  XLEN  effective address (ALU result)
- store_data_i  in  XLEN  rs2 value
- dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_wmask  out  4  byte enables
- dmem_wdata  out  XLEN  lane-shifted store data
- dmem_rdata  in  XLEN  read data
- dmem_resp  in  1  access complete
- load_data_o  out  XLEN  extended load result
- mem_stall  out  1  hold pipeline
- misaligned_o  out  1  misaligned access detected (no request issued)
- stall_cycles_o  out  CNT_W  saturating count of cycles with mem_stall=1

Behaviour:
- States: IDLE, WAIT, DONE. Reset (async) → IDLE. All dmem outputs, `load_data_o`, `mem_stall`, `misaligned_o` and `stall_cycles_o` are 0.
- IDLE, access start:
  - Start condition: `valid_i` & (`is_load_i` | `is_store_i`) & !`flush_i` & !misaligned.
  - Drives `dmem_read`/`dmem_write` combinationally in the same cycle.
  - Sets `mem_stall`=1 and goes to WAIT.
  - Address, mask, wdata and funct3 are captured into internal registers that cycle.
- WAIT:
  - Request outputs are held stable from the captured registers, regardless of input changes.
  - `mem_stall`=1.
  - On `dmem_resp`: latch `dmem_rdata`, deassert requests next cycle, go to DONE.
- DONE:
  - `mem_stall`=0 and `load_data_o` is driven from the latched data.
  - If `advance_i`, go to IDLE; otherwise stay in DONE and hold `load_data_o`.
- Latency:
  - Request in cycle 0, `dmem_resp` in cycle N (N≥0 if resp arrives same cycle).
  - Result visible and stall low in cycle N+1. Minimum stall = 1 cycle.
- Back-to-back accesses: a new access may start only in IDLE. The first IDLE cycle after DONE may issue immediately.
- Misalignment:
  - Cases: LW/SW with addr[1:0]≠0; LH/LHU/SH with addr[0]=1.
  - Effect: `misaligned_o`=1 combinationally, no request, no stall, state stays IDLE.
- Store formatting:
  - SB: mask=4'b0001<<addr[1:0], wdata={4{sd[7:0]}}.
  - SH: mask=4'b0011<<addr[1:0], wdata={2{sd[15:0]}}.
  - SW: mask=4'b1111, wdata=sd.
  - `dmem_wmask`=0 for loads.
- Load extension (selecting the byte/half by the captured addr[1:0]):
  - LB (000): sign-extend.
  - LH (001): sign-extend.
  - LW (010): full word.
  - LBU (100): zero-extend.
  - LHU (101): zero-extend.
  - Other funct3: result 0.
  - For stores, `load_data_o`=0.
- Flush:
  - In IDLE: no request is issued.
  - In WAIT: the request is NOT cancelled and the stall holds until resp. Then go directly to IDLE, skip DONE, and keep `load_data_o`=0.
  - In DONE: go to IDLE next cycle and clear the result.
- Reset mid-WAIT: state aborts to IDLE asynchronously and requests drop immediately. Memory must tolerate the dropped request.
- `stall_cycles_o`: increments every cycle `mem_stall`=1 and saturates at all-ones.

Test Plan:
- LW addr 0x100, dmem_rdata 0xDEADBEEF, resp after 3 cycles → `dmem_read` high 4 cycles, `mem_stall` high 4 cycles, `load_data_o`=0xDEADBEEF in the following cycle, `stall_cycles_o`=4.
- LB addr 0x103, rdata 0x80FF1234 → `load_data_o`=0xFFFFFF80; LBU same → 0x00000080; LH addr 0x102 → 0xFFFF80FF.
- SB addr 0x201, store_data 0x000000AB, resp same cycle → `dmem_addr` 0x200, wmask 0b0010, wdata 0xABABABAB, stall 1 cycle.
- SH addr 0x203 → `misaligned_o`=1, no `dmem_read`/`dmem_write`, `mem_stall`=0.
- `flush_i` pulsed during WAIT of an LW, resp 2 cycles later → request held until resp, no DONE cycle, `load_data_o`=0.
- `rst` asserted mid-WAIT between clock edges → `dmem_read` and `mem_stall` fall without a clock edge, and state is IDLE after release.
